disp_src_arbiter: RTL and testbench

- Arbitration and sequencing controller for the 64-bit 2:1 display/IO data multiplexer.
- Two requesters each present a 64-bit word and a request. The block grants one of them and drives the mux select `s`.
- It captures the selected word into a registered output and holds it for a minimum number of cycles. It then completes a valid/ready handshake with the downstream consumer (display/shift driver) before it re-arbitrates.
- Sits between the data sources and the output driver in the IO subsystem.

---
 rtl/disp_src_arbiter.sv | 144 ++++++++++++++
 tb/tb_disp_src_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/disp_src_arbiter.sv
// Grant/sequencing controller for the 64-bit 2:1 display/IO data mux: arbitrates two requesters,
// captures and holds the selected word, then hands it off downstream. Define ARB_FIXED_PRIO_EN for fixed priority.
module disp_src_arbiter #(
    parameter int HOLD_CYCLES = 16,
    parameter int CW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] I0,
    input  logic [63:0] I1,
    input  logic        out_ready,
    output logic        s,
    output logic        gnt0,
    output logic        gnt1,
    output logic [63:0] o,
    output logic        o_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic          s_q, s_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic [63:0]   o_q, o_d;
    logic          o_valid_q, o_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lg_q, lg_d;

    logic any_req;
    logic win;
    logic xfer;
    logic hold_done;

    assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
    // req0 wins whenever it is present; lg is tracked but ignored.
    assign win = ~req0;
`else
    // A lone requester wins; on a tie the side not granted last time wins.
    assign win = (req0 & req1) ? ~lg_q : req1;
`endif

    assign xfer      = o_valid_q & out_ready;
    assign hold_done = (cnt_q == '0) & (~o_valid_q | xfer);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        cnt_d     = cnt_q;
        lg_d      = lg_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_LOAD;
                    s_d     = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end

            ST_LOAD: begin
                o_d       = s_q ? I1 : I0;
                o_valid_d = 1'b1;
                cnt_d     = CNT_INIT;
                lg_d      = s_q;
                state_d   = ST_HOLD;
            end

            ST_HOLD: begin
                if (xfer) begin
                    o_valid_d = 1'b0;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                // Re-arbitrate only once the word is handed off and the minimum hold has elapsed.
                if (hold_done) begin
                    if (any_req) begin
                        state_d = ST_LOAD;
                        s_d     = win;
                        gnt0_d  = ~win;
                        gnt1_d  = win;
                    end else begin
                        state_d = ST_IDLE;
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_q       <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            o_q       <= 64'h0;
            o_valid_q <= 1'b0;
            cnt_q     <= '0;
            lg_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            cnt_q     <= cnt_d;
            lg_q      <= lg_d;
        end
    end

    assign s       = s_q;
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_disp_src_arbiter.sv
// Self-checking bench for disp_src_arbiter (HOLD_CYCLES=4): directed timing checks plus a
// scoreboard of expected {select, word} pairs popped at every downstream transfer.
module tb_disp_src_arbiter;

    localparam int HC = 4;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] I0 = 64'h0;
    logic [63:0] I1 = 64'h0;
    logic        s, gnt0, gnt1, o_valid, busy;
    logic [63:0] o;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          started  = 1'b0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    disp_src_arbiter #(.HOLD_CYCLES(HC), .CW(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .I0(I0), .I1(I1), .out_ready(out_ready),
        .s(s), .gnt0(gnt0), .gnt1(gnt1), .o(o), .o_valid(o_valid), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic es, input logic eg0, input logic eg1,
                             input logic ev, input logic eb);
        check({tag, ".s"},       64'(s),       64'(es));
        check({tag, ".gnt0"},    64'(gnt0),    64'(eg0));
        check({tag, ".gnt1"},    64'(gnt1),    64'(eg1));
        check({tag, ".o_valid"}, 64'(o_valid), 64'(ev));
        check({tag, ".busy"},    64'(busy),    64'(eb));
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        tick(2);
        check("rst.busy", 64'(busy), 64'd0);
        rst = 1'b0;
    endtask

    // Transfer monitor: a transfer happens at the next edge when o_valid & out_ready with rst low.
    always @(negedge clk) begin
        logic [64:0] e;
        if (started) begin
            check("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
            if (gnt0 | gnt1) check("gnt_s", 64'(s), 64'(gnt1));
            if (!rst && o_valid && out_ready) begin
                check("sb_depth", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("xfer_o", o, e[63:0]);
                    check("xfer_s", 64'(s), 64'(e[64]));
                    $display("xfer: s=%0d o=%h", s, o);
                end
            end
        end
    end

    initial begin
        logic w;
        // Reset held with both requests high.
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_ctl("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst1.o", o, 64'h0);
        tick();
        check_ctl("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst2.o", o, 64'h0);
        started = 1'b1;
        rst = 1'b0;
        tick();
        check_ctl("rst_rel", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Single requester, latency and back-to-back re-grant.
        do_reset();
        I0 = 64'hDEAD_BEEF_0123_4567; req0 = 1'b1; out_ready = 1'b1;
        exp_q.push_back({1'b0, I0});
        tick();
        check_ctl("sgl_e1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_ctl("sgl_e2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("sgl_e2.o", o, 64'hDEAD_BEEF_0123_4567);
        tick();
        check_ctl("sgl_e3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        I0 = 64'h0F0F_1234_5678_A5A5;
        exp_q.push_back({1'b0, I0});
        tick(3);
        check_ctl("sgl_e6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("sgl_e6.o", o, 64'hDEAD_BEEF_0123_4567);
        req0 = 1'b0;
        tick();
        check_ctl("sgl_e7", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("sgl_e7.o", o, 64'h0F0F_1234_5678_A5A5);
        tick(3);
        check_ctl("sgl_e10", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_ctl("sgl_e11", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Tie: alternating grants (round-robin) or all to requester 0 (fixed priority).
        do_reset();
        I0 = 64'hAAAA_0000_AAAA_0000; I1 = 64'hBBBB_1111_BBBB_1111;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = FIXED ? 1'b0 : 1'(k % 2);
            exp_q.push_back({w, w ? I1 : I0});
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            w = FIXED ? 1'b0 : 1'(k % 2);
            check_ctl($sformatf("tie_g%0d", k), w, ~w, w, 1'b0, 1'b1);
            if (k < 3) begin
                tick(4);
                check_ctl($sformatf("tie_h%0d", k), w, ~w, w, 1'b0, 1'b1);
                tick();
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(5);
        check_ctl("tie_end", FIXED ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure for 40 cycles, exit on the edge out_ready is seen.
        do_reset();
        I1 = 64'hC0DE_CAFE_F00D_0042; req1 = 1'b1;
        exp_q.push_back({1'b1, I1});
        tick();
        check_ctl("bp_e1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_ctl("bp_e2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        req1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("bp_hold.o", o, 64'hC0DE_CAFE_F00D_0042);
            check_ctl("bp_hold", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check_ctl("bp_exit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;

        // Requester drops in HOLD; transfer on the same edge the counter is already zero.
        do_reset();
        I1 = 64'h1; req1 = 1'b1;
        exp_q.push_back({1'b1, I1});
        tick(2);
        check_ctl("drop_e2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        req1 = 1'b0;
        tick(3);
        check_ctl("drop_e5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("drop_e5.o", o, 64'h1);
        out_ready = 1'b1;
        tick();
        check_ctl("drop_e6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_e6.o", o, 64'h1);
        out_ready = 1'b0;

        // Reset in HOLD while a transfer would otherwise complete.
        do_reset();
        I0 = 64'hE0E0_E0E0_E0E0_E0E0; req0 = 1'b1;
        tick(2);
        check_ctl("rsth_e2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        check_ctl("rsth_e3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rsth_e3.o", o, 64'h0);
        rst = 1'b0; req0 = 1'b0;
        tick(2);
        check_ctl("rsth_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
